msg_scheduler: RTL
==================

Name: msg_scheduler

Overview:
- Upstream neighbour of the round-compression stage. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream.
- It expands the block on the fly into the 64-word schedule W0..W63.
- Each cycle it drives the compressor with W_t, the round index and the 2-bit phase code, plus a one-cycle start pulse.
- It is the sole owner of round sequencing for one block.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- ROUNDS, 64, compression rounds per block.
- DRAIN_CYCLES, 8, cycles held in the DRAIN phase so the compressor can emit its eight digest words.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- word_in  in  DATA_WIDTH  message word, big-endian word order, W0 first
- word_valid_in  in  1  word_in valid
- word_ready_out  out  1  scheduler can accept a word
- start_out  out  1  one-cycle pulse; compressor loads initial hash
- w_out  out  DATA_WIDTH  schedule word W_t for the current round
- round_out  out  6  current round index t
- fsm_state_out  out  2  phase code: 00 IDLE/LOAD, 01 rounds 0-15, 10 rounds 16-63, 11 DRAIN
- busy_out  out  1  high from first accepted word until DRAIN ends

Behaviour:
- Reset (asynchronous, active-low rst_n): everything is zeroed.
  - word_ready_out=0 during reset, and 1 in the first cycle after release.
  - start_out=0, w_out=0, round_out=0, fsm_state_out=00, busy_out=0.
  - load counter=0 and all 16 buffer entries=0.
  - A reset mid-block aborts it: no start pulse, no partial output.
- Storage: 16-entry word shift register buf[0..15]; buf[0] is the oldest word.
- State IDLE/LOAD (code 00):
  - word_ready_out=1 while load count < 16.
  - A word is accepted on a cycle with valid&ready: it shifts into buf[15] and the count increments.
  - word_valid_in with ready=0 is ignored and the word is not consumed.
  - The cycle after the 16th word is accepted: word_ready_out=0, start_out=1 for exactly one cycle, round_out=0, fsm_state_out still 00.
  - The next cycle enters ROUND.
- State ROUND:
  - fsm_state_out=01 for t=0..15 and 10 for t=16..63.
  - round_out=t and w_out=buf[0]=W_t, both combinationally aligned in the same cycle.
  - Each cycle buf shifts down one entry; buf[15] receives sigma1(buf[14]) + buf[9] + sigma0(buf[1]) + buf[0], all sums mod 2^32.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Latency: 64 cycles; the round counter increments once per cycle with no stalls.
  - After t=63 the scheduler enters DRAIN; round_out holds at 63.
- State DRAIN (code 11):
  - Lasts DRAIN_CYCLES cycles, with round_out=63 and w_out=0.
  - Then returns to IDLE/LOAD: word_ready_out=1, count=0, busy_out=0.
- Back-to-back blocks: words offered during ROUND or DRAIN stall (ready=0). The first word of the next block is accepted on the cycle after DRAIN exits.
- The 6-bit round counter never wraps past 63; the exit from ROUND is taken at t=63.
- word_valid_in high continuously: exactly 16 words are taken per block, never 17.

Decomposition:
- Shared package sha256_pkg holds:
  - phase codes ST_IDLE=2'b00, ST_RND_LO=2'b01, ST_RND_HI=2'b10, ST_DRAIN=2'b11;
  - WORDS_PER_BLOCK=16 and ROUNDS=64.
  - The same codes are used by the compressor's FSM_state_in decode.
- One natural sub-module, msg_sigma: purely combinational, DATA_WIDTH in, produces sigma0 and sigma1 outputs.
- The FSM, counters and buffer stay in msg_scheduler.

Test Plan:
- Reset check: assert rst_n=0 mid-ROUND at t=20, then release -> all outputs at reset values and no start pulse. A fresh 16-word load then completes normally.
- "abc" block: stream 0x61626380, 0x0 x14, 0x00000018 with continuous valid.
  - Expect start_out one cycle after the 16th handshake.
  - Expect w_out=0x61626380 at t=0, w_out=0x00000018 at t=15, 0x61626380 at t=16, 0x000F0000 at t=17.
  - Expect fsm_state_out 01 up to t=15, then 10.
- Connected to the compressor with the same "abc" block -> digest words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Gappy valid: toggle word_valid_in every other cycle -> exactly 16 words captured in order, and the schedule is identical to the continuous case.
- Back-pressure: hold word_valid_in=1 throughout two blocks ->
  - word_ready_out=0 for the whole of ROUND plus 8 DRAIN cycles;
  - the second block's W0 is the 17th word offered;
  - round_out sequence is 0..63 with no gaps.
- Boundary: observe t=63 then DRAIN -> round_out holds at 63 for 8 cycles with fsm_state_out=11, then returns to 00 with busy_out=0.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared phase codes, block geometry and the scheduler FSM
//                encoding for the SHA-256 message scheduler / compressor pair.
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

    // Phase codes seen on the scheduler/compressor boundary
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RND_LO = 2'b01;
    localparam logic [1:0] ST_RND_HI = 2'b10;
    localparam logic [1:0] ST_DRAIN  = 2'b11;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int ROUNDS          = 64;

    // Internal scheduler states; START is the one-cycle start-pulse slot
    typedef enum logic [1:0] {
        SCH_LOAD  = 2'd0,
        SCH_START = 2'd1,
        SCH_ROUND = 2'd2,
        SCH_DRAIN = 2'd3
    } sched_state_e;

    // Map an internal state plus round index onto the external phase code
    function automatic logic [1:0] phase_code(input sched_state_e st, input logic [5:0] rnd);
        logic [1:0] code;
        case (st)
            SCH_ROUND: code = (rnd < 6'(WORDS_PER_BLOCK)) ? ST_RND_LO : ST_RND_HI;
            SCH_DRAIN: code = ST_DRAIN;
            default:   code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_sigma.sv
`default_nettype none
// ============================================================================
//  Module      : msg_sigma
//  Description : Combinational SHA-256 message-schedule small sigma functions.
//                sigma0 = ROTR7 ^ ROTR18 ^ SHR3, sigma1 = ROTR17 ^ ROTR19 ^ SHR10
//  Revision    : 1.0  initial release
// ============================================================================
module msg_sigma #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] s0_in,
    input  logic [DATA_WIDTH-1:0] s1_in,
    output logic [DATA_WIDTH-1:0] sigma0_out,
    output logic [DATA_WIDTH-1:0] sigma1_out
);

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                    input int unsigned n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    // Both sigmas evaluated in parallel for the expansion adder tree
    always_comb begin
        sigma0_out = rotr(s0_in, 7)  ^ rotr(s0_in, 18) ^ (s0_in >> 3);
        sigma1_out = rotr(s1_in, 17) ^ rotr(s1_in, 19) ^ (s1_in >> 10);
    end

endmodule
`default_nettype wire

// File: rtl/msg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : msg_scheduler
//  Description : Accepts a 16-word message block over valid/ready, expands it
//                on the fly into W0..W63 and sequences the compressor rounds,
//                followed by a fixed drain window for digest output.
//  Revision    : 1.0  initial release
// ============================================================================
module msg_scheduler
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,   // only 32 is meaningful for SHA-256
    parameter int ROUNDS       = 64,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] word_in,
    input  logic                  word_valid_in,
    output logic                  word_ready_out,
    output logic                  start_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [5:0]            round_out,
    output logic [1:0]            fsm_state_out,
    output logic                  busy_out
);

    localparam int              DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [5:0]      LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [4:0]      LAST_WORD  = 5'(WORDS_PER_BLOCK - 1);
    localparam logic [4:0]      FULL_COUNT = 5'(WORDS_PER_BLOCK);

    typedef logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] word_buf_t;

    sched_state_e        state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [5:0]          round_q, round_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    word_buf_t           buf_q,   buf_d;
    logic                ready_q, ready_d;
    logic                start_q, start_d;
    logic                busy_q,  busy_d;
    logic [1:0]          phase_q, phase_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] sigma0;
    logic [DATA_WIDTH-1:0] sigma1;
    logic [DATA_WIDTH-1:0] w_next;

    // Small sigmas over the taps W[t+1] and W[t+14] of the sliding window
    msg_sigma #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sigma (
        .s0_in      (buf_q[1]),
        .s1_in      (buf_q[14]),
        .sigma0_out (sigma0),
        .sigma1_out (sigma1)
    );

    // Next-state, counter and window update for load, rounds and drain
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        round_d = round_q;
        drain_d = drain_q;
        buf_d   = buf_q;
        busy_d  = busy_q;
        accept  = (state_q == SCH_LOAD) && ready_q && word_valid_in;
        w_next  = sigma1 + buf_q[9] + sigma0 + buf_q[0];

        case (state_q)
            SCH_LOAD: begin
                if (accept) begin
                    buf_d   = {word_in, buf_q[WORDS_PER_BLOCK-1:1]};
                    count_d = count_q + 5'd1;
                    busy_d  = 1'b1;
                    if (count_q == LAST_WORD) begin
                        state_d = SCH_START;
                    end
                end
            end
            SCH_START: begin
                state_d = SCH_ROUND;
                round_d = 6'd0;
            end
            SCH_ROUND: begin
                // buf[0] is consumed this cycle; W[t+16] enters at the top
                buf_d = {w_next, buf_q[WORDS_PER_BLOCK-1:1]};
                if (round_q == LAST_ROUND) begin
                    state_d = SCH_DRAIN;
                    drain_d = '0;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            default: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = SCH_LOAD;
                    count_d = 5'd0;
                    round_d = 6'd0;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
        endcase

        ready_d = (state_d == SCH_LOAD) && (count_d < FULL_COUNT);
        start_d = (state_d == SCH_START);
        phase_d = phase_code(state_d, round_d);
    end

    // State and output registers; async reset aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCH_LOAD;
            count_q <= 5'd0;
            round_q <= 6'd0;
            drain_q <= '0;
            buf_q   <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            phase_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            round_q <= round_d;
            drain_q <= drain_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            phase_q <= phase_d;
        end
    end

    assign word_ready_out = ready_q;
    assign start_out      = start_q;
    assign round_out      = round_q;
    assign fsm_state_out  = phase_q;
    assign busy_out       = busy_q;
    // W_t is presented only during rounds; zero while loading and draining
    assign w_out          = (state_q == SCH_ROUND) ? buf_q[0] : '0;

endmodule
`default_nettype wire
